// File: rtl/key_pkg.sv
// Shared types and constants for the push-button debounce path.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } key_state_e;

   // Stable-time count for 20 ms at 50 MHz.
   localparam int unsigned KEY_CNT_20MS = 1_000_000;

endpackage : key_pkg

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Synchronous active-low reset loads both flops with RST_VAL.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule : sync_2ff

// File: rtl/key_debounce.sv
// Debounces the active-low key pin into a clean pressed level
// plus one-cycle press/release strobes.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned CNT_MAX = KEY_CNT_20MS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_filter,
   output logic key_press,
   output logic key_release
);

   localparam int unsigned CNT_W = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

   logic             key_s;
   key_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             filter_q;
   logic             press_q;
   logic             release_q;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (key_in),
      .q_o    (key_s)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         filter_q  <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!key_s) begin
                  state_q <= PRESS_CHK;
                  cnt_q   <= '0;
               end
            end
            PRESS_CHK: begin
               if (key_s) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q  <= PRESSED;
                  cnt_q    <= '0;
                  filter_q <= 1'b1;
                  press_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            PRESSED: begin
               if (key_s) begin
                  state_q <= RELEASE_CHK;
                  cnt_q   <= '0;
               end
            end
            RELEASE_CHK: begin
               // A low excursion here is bounce: fall back without touching the level.
               if (!key_s) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= IDLE;
                  cnt_q     <= '0;
                  filter_q  <= 1'b0;
                  release_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign key_filter  = filter_q;
   assign key_press   = press_q;
   assign key_release = release_q;

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with CNT_MAX = 4.
module tb_key_debounce;

   typedef struct {
      int unsigned at_edge;
      logic        is_press;
   } ev_t;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic key_in = 1'b1;
   logic key_filter;
   logic key_press;
   logic key_release;

   int unsigned cyc      = 0;
   logic        rst_seen = 1'b0;
   int          checks   = 0;
   int          failures = 0;
   logic        level    = 1'b0;
   ev_t         q[$];

   key_debounce #(
      .CNT_MAX (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .key_filter  (key_filter),
      .key_press   (key_press),
      .key_release (key_release)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst_n;
   end

   task automatic check(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d actual=%b required=%b", nm, cyc, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_key(input logic v);
      @(posedge clk);
      #1;
      key_in = v;
   endtask

   // Next edge is edge 1 of a held level; the strobe lands on edge 7 (CNT_MAX+3).
   task automatic expect_ev(input logic p);
      q.push_back('{at_edge: cyc + 7, is_press: p});
   endtask

   // Monitor: outputs after edge cyc are sampled on the following falling edge.
   initial begin
      ev_t ev;
      forever begin
         @(negedge clk);
         if (cyc >= 1) begin
            if (!rst_seen) level = 1'b0;
            if (q.size() > 0 && q[0].at_edge == cyc) begin
               ev = q.pop_front();
               check("press_strobe", key_press, ev.is_press);
               check("release_strobe", key_release, !ev.is_press);
               level = ev.is_press;
            end else begin
               check("press_quiet", key_press, 1'b0);
               check("release_quiet", key_release, 1'b0);
            end
            check("key_filter", key_filter, level);
         end
      end
   end

   initial begin
      // Reset held 3 edges with the pin toggling
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         key_in = ~key_in;
      end
      rst_n  = 1'b1;
      key_in = 1'b1;
      tick(10);

      // Clean press then clean release
      set_key(1'b0); expect_ev(1'b1); tick(19);
      set_key(1'b1); expect_ev(1'b0); tick(19);

      // Press bounce: low 3, high 1, low 2, high 1, then low held
      set_key(1'b0); tick(2);
      set_key(1'b1);
      set_key(1'b0); tick(1);
      set_key(1'b1);
      set_key(1'b0); expect_ev(1'b1); tick(19);

      // Release bounce: high 2 then low held
      set_key(1'b1); tick(1);
      set_key(1'b0); tick(19);

      // Clean release back to idle
      set_key(1'b1); expect_ev(1'b0); tick(19);

      // Reset mid-check: rst_n sampled low at edges 4 and 5 of the press
      set_key(1'b0); tick(3);
      rst_n = 1'b0; tick(2);
      rst_n = 1'b1; expect_ev(1'b1); tick(19);
      set_key(1'b1); expect_ev(1'b0); tick(19);

      tick(2);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL pending_events actual=%0d required=0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_key_debounce
